// File: rtl/ysyx_22041071_axi_rd_slave_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_22041071_axi_rd_slave_pkg
// Shared definitions for the AXI4 read-channel responder:
//   - AXI burst-type and response codes
//   - default AXI channel widths
//   - read FSM state encoding
//   - burst legality helper used at AR acceptance
// ---------------------------------------------------------------------------
package ysyx_22041071_axi_rd_slave_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int AXI_DATA_WIDTH = 64;
  localparam int AXI_ADDR_WIDTH = 64;
  localparam int AXI_ID_WIDTH   = 4;
  localparam int AXI_LEN_WIDTH  = 8;
  localparam int AXI_SIZE_WIDTH = 3;

  typedef enum logic {
    ST_IDLE,
    ST_ISSUE
  } rd_state_e;

  // A burst is rejected as a whole when its beat size exceeds the bus,
  // its type is reserved, or it is a WRAP of a length AXI does not allow.
  function automatic logic burst_is_bad(input logic [1:0] burst,
                                        input logic [7:0] len,
                                        input logic [2:0] size,
                                        input logic [2:0] max_size);
    logic bad;
    bad = (size > max_size) || (burst == BURST_RSVD);
    if ((burst == BURST_WRAP) &&
        !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15)))
      bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/ysyx_22041071_axi_r_skid.sv
// ---------------------------------------------------------------------------
// ysyx_22041071_axi_r_skid
// Two-entry FIFO holding R-channel beats {id, data, resp, last}.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   in_valid/in_ready   write side handshake, in_data is the packed beat
//   out_valid/out_ready read side handshake, out_data is the head beat
//   count               current occupancy (0..2), used upstream for credit
// Push and pop may happen in the same cycle at any occupancy. Storage is
// cleared on reset so the R payload reads as zero afterwards.
// ---------------------------------------------------------------------------
module ysyx_22041071_axi_r_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] slot_q [2];
  logic [WIDTH-1:0] slot_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             push, pop;

  always_comb begin
    out_valid = (count_q != 2'd0);
    // When full, a pop frees the slot being written this same edge.
    in_ready  = (count_q != 2'd2) || out_ready;
    pop       = out_valid && out_ready;
    push      = in_valid && in_ready;
    out_data  = slot_q[rd_ptr_q];
    count     = count_q;

    slot_d[0] = slot_q[0];
    slot_d[1] = slot_q[1];
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;

    if (push) begin
      slot_d[wr_ptr_q] = in_data;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop)
      rd_ptr_d = ~rd_ptr_q;

    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      slot_q[0] <= slot_d[0];
      slot_q[1] <= slot_d[1];
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: rtl/ysyx_22041071_axi_rd_slave.sv
// ---------------------------------------------------------------------------
// ysyx_22041071_axi_rd_slave
// AXI4 read responder (AR + R) in front of a single-port synchronous memory
// with one cycle of read latency.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   s_ar_*                AR channel (valid/ready, id, addr, len, size, burst)
//   s_r_*                 R channel (valid/ready, id, data, resp, last)
//   mem_en/mem_addr       memory read strobe and word address
//   mem_rdata             memory data for the previous cycle's mem_en
// One beat is issued per cycle while the R buffer has credit. Each issued
// beat spends one cycle in flight (memory latency) before entering the
// two-entry R buffer, so beats leave in exactly the order they were issued.
// ---------------------------------------------------------------------------
module ysyx_22041071_axi_rd_slave
  import ysyx_22041071_axi_rd_slave_pkg::*;
#(
  parameter int                    DATA_WIDTH = AXI_DATA_WIDTH,
  parameter int                    ADDR_WIDTH = AXI_ADDR_WIDTH,
  parameter int                    ID_WIDTH   = AXI_ID_WIDTH,
  parameter int                    MEM_AW     = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h8000_0000,
  parameter logic [ADDR_WIDTH-1:0] SIZE_BYTES = 'h0008_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_ar_valid,
  output logic                  s_ar_ready,
  input  logic [ID_WIDTH-1:0]   s_ar_id,
  input  logic [ADDR_WIDTH-1:0] s_ar_addr,
  input  logic [7:0]            s_ar_len,
  input  logic [2:0]            s_ar_size,
  input  logic [1:0]            s_ar_burst,
  output logic                  s_r_valid,
  input  logic                  s_r_ready,
  output logic [ID_WIDTH-1:0]   s_r_id,
  output logic [DATA_WIDTH-1:0] s_r_data,
  output logic [1:0]            s_r_resp,
  output logic                  s_r_last,
  output logic                  mem_en,
  output logic [MEM_AW-1:0]     mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int         BEAT_SHIFT = $clog2(DATA_WIDTH / 8);
  localparam logic [2:0] MAX_SIZE   = 3'(BEAT_SHIFT);
  localparam int         PAY_W      = ID_WIDTH + DATA_WIDTH + 3;

  rd_state_e             state_q, state_d;
  logic                  ar_ready_q, ar_ready_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic [7:0]            beat_cnt_q, beat_cnt_d;
  logic                  burst_err_q, burst_err_d;

  // In-flight beat: issued last cycle, its memory data arrives this cycle.
  logic                  pend_valid_q, pend_valid_d;
  logic                  pend_err_q, pend_err_d;
  logic [ID_WIDTH-1:0]   pend_id_q, pend_id_d;
  logic                  pend_last_q, pend_last_d;

  logic                  ar_fire, issue_fire, credit_ok, last_beat;
  logic                  in_window, beat_err, r_pop;
  logic [ADDR_WIDTH-1:0] step, wrap_mask, incr_addr, next_addr, beat_off;
  logic [2:0]            occupancy;

  logic                  skid_in_ready;
  logic [PAY_W-1:0]      skid_in_data, skid_out_data;
  logic [1:0]            skid_count;

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    addr_d      = addr_q;
    len_d       = len_q;
    size_d      = size_q;
    burst_d     = burst_q;
    beat_cnt_d  = beat_cnt_q;
    burst_err_d = burst_err_q;

    ar_fire   = ar_ready_q && s_ar_valid;
    r_pop     = s_r_valid && s_r_ready;

    step      = ADDR_WIDTH'(1) << size_q;
    wrap_mask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
    incr_addr = addr_q + step;
    case (burst_q)
      BURST_FIXED: next_addr = addr_q;
      // Keep the bits above the wrap boundary, let the low bits roll over.
      BURST_WRAP:  next_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
      default:     next_addr = incr_addr;
    endcase

    beat_off  = addr_q - BASE_ADDR;
    in_window = (addr_q >= BASE_ADDR) && (beat_off < SIZE_BYTES);
    beat_err  = burst_err_q || !in_window;
    last_beat = (beat_cnt_q == len_q);

    // A pop this cycle frees a slot in time for the beat issued now.
    occupancy = {1'b0, skid_count} + {2'b00, pend_valid_q};
    credit_ok = (occupancy - {2'b00, r_pop}) < 3'd2;

    issue_fire = (state_q == ST_ISSUE) && credit_ok;
    mem_en     = issue_fire && !beat_err;
    mem_addr   = MEM_AW'(beat_off >> BEAT_SHIFT);

    case (state_q)
      ST_IDLE: begin
        if (ar_fire) begin
          id_d        = s_ar_id;
          addr_d      = (s_ar_burst == BURST_WRAP)
                        ? (s_ar_addr & ~((ADDR_WIDTH'(1) << s_ar_size) - ADDR_WIDTH'(1)))
                        : s_ar_addr;
          len_d       = s_ar_len;
          size_d      = s_ar_size;
          burst_d     = s_ar_burst;
          beat_cnt_d  = 8'd0;
          burst_err_d = burst_is_bad(s_ar_burst, s_ar_len, s_ar_size, MAX_SIZE);
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (issue_fire) begin
          addr_d     = next_addr;
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (last_beat)
            state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ar_ready_d   = (state_d == ST_IDLE);
    pend_valid_d = issue_fire;
    pend_err_d   = beat_err;
    pend_id_d    = id_q;
    pend_last_d  = last_beat;

    // Error beats carry zero data and never touched the memory.
    skid_in_data = {pend_id_q,
                    pend_err_q ? {DATA_WIDTH{1'b0}} : mem_rdata,
                    pend_err_q ? RESP_SLVERR : RESP_OKAY,
                    pend_last_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ar_ready_q   <= 1'b0;
      id_q         <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      size_q       <= '0;
      burst_q      <= '0;
      beat_cnt_q   <= '0;
      burst_err_q  <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_err_q   <= 1'b0;
      pend_id_q    <= '0;
      pend_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ar_ready_q   <= ar_ready_d;
      id_q         <= id_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      size_q       <= size_d;
      burst_q      <= burst_d;
      beat_cnt_q   <= beat_cnt_d;
      burst_err_q  <= burst_err_d;
      pend_valid_q <= pend_valid_d;
      pend_err_q   <= pend_err_d;
      pend_id_q    <= pend_id_d;
      pend_last_q  <= pend_last_d;
    end
  end

  assign s_ar_ready = ar_ready_q;

  ysyx_22041071_axi_r_skid #(
    .WIDTH (PAY_W)
  ) u_r_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (pend_valid_q && skid_in_ready),
    .in_ready  (skid_in_ready),
    .in_data   (skid_in_data),
    .out_valid (s_r_valid),
    .out_ready (s_r_ready),
    .out_data  (skid_out_data),
    .count     (skid_count)
  );

  assign {s_r_id, s_r_data, s_r_resp, s_r_last} = skid_out_data;

endmodule

// File: tb/tb_ysyx_22041071_axi_rd_slave.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22041071_axi_rd_slave
// Directed bench for the AXI read responder. A behavioural memory returns
// {48'hC0DE_0000_0000, word_address} one cycle after mem_en, so the expected
// data of every beat follows directly from its word index.
// ---------------------------------------------------------------------------
module tb_ysyx_22041071_axi_rd_slave;

  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam logic [63:0] SIZE = 64'h0008_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_ar_valid;
  logic        s_ar_ready;
  logic [3:0]  s_ar_id;
  logic [63:0] s_ar_addr;
  logic [7:0]  s_ar_len;
  logic [2:0]  s_ar_size;
  logic [1:0]  s_ar_burst;
  logic        s_r_valid;
  logic        s_r_ready;
  logic [3:0]  s_r_id;
  logic [63:0] s_r_data;
  logic [1:0]  s_r_resp;
  logic        s_r_last;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic [63:0] mem_rdata = 64'd0;

  always #5 clk = ~clk;

  ysyx_22041071_axi_rd_slave dut (
    .clk        (clk),
    .reset      (reset),
    .s_ar_valid (s_ar_valid),
    .s_ar_ready (s_ar_ready),
    .s_ar_id    (s_ar_id),
    .s_ar_addr  (s_ar_addr),
    .s_ar_len   (s_ar_len),
    .s_ar_size  (s_ar_size),
    .s_ar_burst (s_ar_burst),
    .s_r_valid  (s_r_valid),
    .s_r_ready  (s_r_ready),
    .s_r_id     (s_r_id),
    .s_r_data   (s_r_data),
    .s_r_resp   (s_r_resp),
    .s_r_last   (s_r_last),
    .mem_en     (mem_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata)
  );

  // Synchronous memory, one cycle read latency.
  always @(posedge clk)
    if (mem_en) mem_rdata <= {48'hC0DE_0000_0000, mem_addr};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    int          cyc;
  } beat_t;

  beat_t       beats[$];
  logic [15:0] memAddrs[$];
  int          memCount = 0;
  int          total = 0;
  int          bad = 0;
  int          hsCyc = 0;
  logic        stalled = 1'b0;
  logic [71:0] held = '0;

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] wordData(input int w);
    return {48'hC0DE_0000_0000, 16'(w)};
  endfunction

  // Observe R handshakes, memory strobes and payload stability mid-cycle.
  always @(negedge clk) begin : monitor
    beat_t b;
    if (mem_en) begin
      memCount++;
      memAddrs.push_back(mem_addr);
    end
    if (!reset && stalled)
      checkOutput("r payload stable",
                  128'({s_r_valid, s_r_id, s_r_data, s_r_resp, s_r_last}), 128'(held));
    stalled = !reset && s_r_valid && !s_r_ready;
    held    = {s_r_valid, s_r_id, s_r_data, s_r_resp, s_r_last};
    if (!reset && s_r_valid && s_r_ready) begin
      b.id   = s_r_id;
      b.data = s_r_data;
      b.resp = s_r_resp;
      b.last = s_r_last;
      b.cyc  = cyc;
      beats.push_back(b);
    end
  end

  task automatic clearLog();
    beats.delete();
    memAddrs.delete();
    memCount = 0;
  endtask

  // Called just after a rising edge; returns just after the handshake edge.
  task automatic applyStimulus(input logic [3:0] id, input logic [63:0] addr,
                               input logic [7:0] len, input logic [2:0] size,
                               input logic [1:0] burst);
    int waited = 0;
    s_ar_valid = 1'b1;
    s_ar_id    = id;
    s_ar_addr  = addr;
    s_ar_len   = len;
    s_ar_size  = size;
    s_ar_burst = burst;
    @(negedge clk);
    while (!s_ar_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("ar accepted", 128'(s_ar_ready), 128'(1));
    hsCyc = cyc;
    @(posedge clk);
    #1;
    s_ar_valid = 1'b0;
  endtask

  task automatic waitBeats(input int n, input int limit);
    int waited = 0;
    while (beats.size() < n && waited < limit) begin
      @(negedge clk);
      waited++;
    end
    repeat (4) @(negedge clk);
    checkOutput("beat count", 128'(beats.size()), 128'(n));
    @(posedge clk);
    #1;
  endtask

  task automatic checkBeat(input string tag, input int i, input logic [3:0] id,
                           input logic [63:0] data, input logic [1:0] resp,
                           input logic last, input int expCyc);
    if (i < beats.size()) begin
      checkOutput({tag, " id"},   128'(beats[i].id),   128'(id));
      checkOutput({tag, " data"}, 128'(beats[i].data), 128'(data));
      checkOutput({tag, " resp"}, 128'(beats[i].resp), 128'(resp));
      checkOutput({tag, " last"}, 128'(beats[i].last), 128'(last));
      if (expCyc >= 0)
        checkOutput({tag, " cycle"}, 128'(beats[i].cyc), 128'(expCyc));
    end
  endtask

  initial begin
    int wrapWords[4];
    wrapWords[0] = 3; wrapWords[1] = 0; wrapWords[2] = 1; wrapWords[3] = 2;

    reset      = 1'b1;
    s_ar_valid = 1'b0;
    s_ar_id    = '0;
    s_ar_addr  = '0;
    s_ar_len   = '0;
    s_ar_size  = '0;
    s_ar_burst = '0;
    s_r_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst ar_ready", 128'(s_ar_ready), 128'(0));
    checkOutput("rst r_valid",  128'(s_r_valid),  128'(0));
    checkOutput("rst r_data",   128'(s_r_data),   128'(0));
    checkOutput("rst mem_en",   128'(mem_en),     128'(0));
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("idle ar_ready", 128'(s_ar_ready), 128'(1));

    // INCR len=3 from word 2, full-rate drain with exact latency.
    clearLog();
    applyStimulus(4'd3, BASE + 64'h10, 8'd3, 3'd3, 2'b01);
    waitBeats(4, 40);
    for (int i = 0; i < 4; i++)
      checkBeat("incr", i, 4'd3, wordData(2 + i), 2'b00, i == 3, hsCyc + 3 + i);
    checkOutput("incr mem_en count", 128'(memCount), 128'(4));

    // WRAP len=3 starting at word 3 wraps back to word 0.
    clearLog();
    applyStimulus(4'd5, BASE + 64'h18, 8'd3, 3'd3, 2'b10);
    waitBeats(4, 40);
    for (int i = 0; i < 4; i++) begin
      checkBeat("wrap", i, 4'd5, wordData(wrapWords[i]), 2'b00, i == 3, -1);
      if (i < memAddrs.size())
        checkOutput("wrap mem_addr", 128'(memAddrs[i]), 128'(wrapWords[i]));
    end

    // WRAP len=2 is illegal: whole burst SLVERR, memory untouched.
    clearLog();
    applyStimulus(4'd6, BASE, 8'd2, 3'd3, 2'b10);
    waitBeats(3, 40);
    for (int i = 0; i < 3; i++)
      checkBeat("badwrap", i, 4'd6, 64'd0, 2'b10, i == 2, -1);
    checkOutput("badwrap mem_en count", 128'(memCount), 128'(0));

    // INCR len=7 with RREADY toggling every cycle.
    clearLog();
    fork
      applyStimulus(4'd4, BASE, 8'd7, 3'd3, 2'b01);
      begin
        repeat (40) begin
          @(posedge clk);
          #1;
          s_r_ready = ~s_r_ready;
        end
      end
    join
    s_r_ready = 1'b1;
    waitBeats(8, 60);
    for (int i = 0; i < 8; i++)
      checkBeat("toggle", i, 4'd4, wordData(i), 2'b00, i == 7, -1);

    // Last word of the window is OKAY, the next beat falls outside.
    clearLog();
    applyStimulus(4'd8, BASE + SIZE - 64'd8, 8'd1, 3'd3, 2'b01);
    waitBeats(2, 40);
    checkBeat("edge0", 0, 4'd8, wordData(16'hFFFF), 2'b00, 1'b0, -1);
    checkBeat("edge1", 1, 4'd8, 64'd0, 2'b10, 1'b1, -1);
    checkOutput("edge mem_en count", 128'(memCount), 128'(1));

    // Back-to-back bursts come back in AR order.
    clearLog();
    applyStimulus(4'd1, BASE + 64'h40, 8'd0, 3'd3, 2'b01);
    applyStimulus(4'd2, BASE + 64'h100, 8'd1, 3'd3, 2'b01);
    waitBeats(3, 40);
    checkBeat("b2b0", 0, 4'd1, wordData(8), 2'b00, 1'b1, -1);
    checkBeat("b2b1", 1, 4'd2, wordData(16'h20), 2'b00, 1'b0, -1);
    checkBeat("b2b2", 2, 4'd2, wordData(16'h21), 2'b00, 1'b1, -1);

    // Beat size wider than the bus is rejected.
    clearLog();
    applyStimulus(4'hA, BASE, 8'd0, 3'd4, 2'b01);
    waitBeats(1, 40);
    checkBeat("bigsize", 0, 4'hA, 64'd0, 2'b10, 1'b1, -1);
    checkOutput("bigsize mem_en count", 128'(memCount), 128'(0));

    // FIXED burst re-reads the same word.
    clearLog();
    applyStimulus(4'hB, BASE + 64'h8, 8'd2, 3'd3, 2'b00);
    waitBeats(3, 40);
    for (int i = 0; i < 3; i++)
      checkBeat("fixed", i, 4'hB, wordData(1), 2'b00, i == 2, -1);

    // RREADY held low: only two beats issued, nothing lost; then reset.
    clearLog();
    s_r_ready = 1'b0;
    applyStimulus(4'd7, BASE, 8'd7, 3'd3, 2'b01);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("stall mem_en count", 128'(memCount), 128'(2));
    checkOutput("stall r_valid", 128'(s_r_valid), 128'(1));
    checkOutput("stall no pop", 128'(beats.size()), 128'(0));
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst outputs",
                128'({s_ar_ready, s_r_valid, s_r_id, s_r_data, s_r_resp, s_r_last, mem_en}),
                128'(0));
    reset     = 1'b0;
    s_r_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("post rst no beats", 128'(beats.size()), 128'(0));
    checkOutput("post rst ar_ready", 128'(s_ar_ready), 128'(1));

    // Recovery after reset.
    clearLog();
    applyStimulus(4'd9, BASE + 64'h8, 8'd0, 3'd3, 2'b01);
    waitBeats(1, 40);
    checkBeat("recover", 0, 4'd9, wordData(1), 2'b00, 1'b1, hsCyc + 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
